// File: rtl/input_port_rc.sv
// Router input port: flit FIFO, XY route computation and wormhole request hold.
// Non-head flits arriving outside a packet are discarded and counted.
module input_port_rc #(
  parameter int unsigned FLIT_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CUR_X  = 1,
  parameter int unsigned CUR_Y  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        req,
  input  logic [4:0]        gnt,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);
  localparam logic [1:0] CurX = CUR_X[1:0];
  localparam logic [1:0] CurY = CUR_Y[1:0];

  localparam logic [2:0] PortLocal = 3'd0;
  localparam logic [2:0] PortNorth = 3'd1;
  localparam logic [2:0] PortEast  = 3'd2;
  localparam logic [2:0] PortSouth = 3'd3;
  localparam logic [2:0] PortWest  = 3'd4;

  typedef enum logic [1:0] {StIdle, StRoute, StActive} state_e;

  state_e            r_state, w_state_d;
  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic [2:0]        r_port, w_port_d;
  logic [4:0]        r_req, w_req_d;
  logic [7:0]        r_drop_cnt;

  logic              w_empty, w_push, w_pop, w_fwd_pop, w_drop;
  logic              w_is_head, w_is_tail, w_gnt_hit;
  logic [1:0]        w_dst_x, w_dst_y;
  logic [4:0]        w_port_oh;

  function automatic logic [4:0] port_onehot(input logic [2:0] p);
    logic [4:0] oh;
    oh = 5'b00000;
    case (p)
      PortLocal: oh = 5'b00001;
      PortNorth: oh = 5'b00010;
      PortEast:  oh = 5'b00100;
      PortSouth: oh = 5'b01000;
      PortWest:  oh = 5'b10000;
      default:   oh = 5'b00000;
    endcase
    return oh;
  endfunction

  assign w_empty   = (r_count == '0);
  assign in_ready  = (r_count != Full);
  assign w_push    = in_valid && in_ready;
  assign out_flit  = r_mem[r_rd_ptr];
  assign out_valid = (r_state == StActive) && !w_empty;

  // Type bit 0 marks head/single, bit 1 marks tail/single.
  assign w_is_head = out_flit[FLIT_W-2];
  assign w_is_tail = out_flit[FLIT_W-1];
  assign w_dst_x   = out_flit[3:2];
  assign w_dst_y   = out_flit[1:0];

  assign w_port_oh = port_onehot(r_port);
  assign w_gnt_hit = |(gnt & w_port_oh);
  assign w_fwd_pop = out_valid && w_gnt_hit && out_ready;
  assign w_drop    = (r_state == StIdle) && !w_empty && !w_is_head;
  assign w_pop     = w_fwd_pop || w_drop;

  always_comb begin
    w_state_d = r_state;
    w_port_d  = r_port;
    case (r_state)
      StIdle: begin
        if (!w_empty && w_is_head) w_state_d = StRoute;
      end
      StRoute: begin
        if (w_dst_x > CurX)      w_port_d = PortEast;
        else if (w_dst_x < CurX) w_port_d = PortWest;
        else if (w_dst_y > CurY) w_port_d = PortNorth;
        else if (w_dst_y < CurY) w_port_d = PortSouth;
        else                     w_port_d = PortLocal;
        w_state_d = StActive;
      end
      StActive: begin
        // The request is held across empty gaps until the tail leaves.
        if (w_fwd_pop && w_is_tail) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    w_req_d = (w_state_d == StActive) ? port_onehot(w_port_d) : 5'b00000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_port     <= PortLocal;
      r_req      <= 5'b00000;
      r_drop_cnt <= 8'd0;
    end else begin
      r_state <= w_state_d;
      r_port  <= w_port_d;
      r_req   <= w_req_d;
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_flit;
  end

  assign req      = r_req;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_input_port_rc.sv
// Bench for input_port_rc at CUR=(1,1): routing table plus packet corner sequences,
// with delivered flits checked against a scoreboard queue.
module tb_input_port_rc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_flit;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  req;
  logic [4:0]  gnt;
  logic [7:0]  drop_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  int          pop_cnt = 0;
  logic [15:0] sb [$];
  int          exp_port = 0;
  logic [4:0]  exp_req = 5'b00001;
  bit          gnt_mode = 1'b0;
  logic [4:0]  gnt_force = 5'b00000;

  typedef struct {
    logic [1:0] x;
    logic [1:0] y;
    int         port;
    logic [4:0] req;
  } route_t;

  route_t tbl [9];

  input_port_rc #(
    .FLIT_W(16),
    .DEPTH (4),
    .CUR_X (1),
    .CUR_Y (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_flit  (in_flit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_flit (out_flit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .req      (req),
    .gnt      (gnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Arbiter model: grant follows request one cycle later unless forced.
  always @(posedge clk) begin
    if (rst) gnt <= 5'b00000;
    else     gnt <= gnt_mode ? gnt_force : req;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && gnt[exp_port]) begin
      pop_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        check("pop_flit", {16'd0, out_flit}, {16'd0, sb.pop_front()});
        check("req_hold", {27'd0, req}, {27'd0, exp_req});
      end
    end
  end

  function automatic logic [15:0] mk(input logic [1:0] t, input logic [1:0] x,
                                     input logic [1:0] y, input logic [9:0] tag);
    return {t, tag, x, y};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] f, input bit fwd);
    int k;
    k = 0;
    in_flit  = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("push_timeout", 32'd0, 32'd1);
    if (fwd) sb.push_back(f);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input logic [4:0] want, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (req !== want && k < 30) begin
      @(negedge clk);
      k++;
    end
    check(nm, {27'd0, req}, {27'd0, want});
  endtask

  task automatic set_port(input int p, input logic [4:0] r);
    exp_port = p;
    exp_req  = r;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0;
    logic [15:0] f0;
    int          exp_drop;

    tbl[0] = '{x: 2'd3, y: 2'd1, port: 2, req: 5'b00100};
    tbl[1] = '{x: 2'd0, y: 2'd1, port: 4, req: 5'b10000};
    tbl[2] = '{x: 2'd1, y: 2'd3, port: 1, req: 5'b00010};
    tbl[3] = '{x: 2'd1, y: 2'd0, port: 3, req: 5'b01000};
    tbl[4] = '{x: 2'd1, y: 2'd1, port: 0, req: 5'b00001};
    tbl[5] = '{x: 2'd2, y: 2'd0, port: 2, req: 5'b00100};
    tbl[6] = '{x: 2'd0, y: 2'd3, port: 4, req: 5'b10000};
    tbl[7] = '{x: 2'd3, y: 2'd3, port: 2, req: 5'b00100};
    tbl[8] = '{x: 2'd1, y: 2'd2, port: 1, req: 5'b00010};

    rst       = 1'b1;
    in_flit   = 16'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_req", {27'd0, req}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    step(1);

    // Single flit east: request appears after the third edge counting the push.
    set_port(2, 5'b00100);
    p0 = pop_cnt;
    push(mk(2'b11, 2'd3, 2'd1, 10'h011), 1'b1);
    @(negedge clk);
    check("single_e1_req", {27'd0, req}, 32'd0);
    step(1);
    @(negedge clk);
    check("single_e2_req", {27'd0, req}, 32'd0);
    step(1);
    @(negedge clk);
    check("single_e3_req", {27'd0, req}, {27'd0, 5'b00100});
    check("single_out_valid", {31'd0, out_valid}, 32'd1);
    wait_req(5'b00000, "single_req_fall");
    check("single_pops", pop_cnt - p0, 32'd1);
    step(2);
    @(negedge clk);
    check("single_no_trail_pop", pop_cnt - p0, 32'd1);
    check("single_idle_req", {27'd0, req}, 32'd0);
    step(1);

    for (int i = 0; i < 9; i++) begin
      set_port(tbl[i].port, tbl[i].req);
      p0 = pop_cnt;
      push(mk(2'b11, tbl[i].x, tbl[i].y, 10'h100 + 10'(i)), 1'b1);
      wait_req(tbl[i].req, $sformatf("route_tbl_%0d", i));
      wait_req(5'b00000, $sformatf("route_tbl_fall_%0d", i));
      check($sformatf("route_tbl_pops_%0d", i), pop_cnt - p0, 32'd1);
      step(1);
    end

    // Local packet of four flits, with a new single flit queued right behind the tail.
    set_port(0, 5'b00001);
    p0 = pop_cnt;
    push(mk(2'b01, 2'd1, 2'd1, 10'h200), 1'b1);
    push(mk(2'b00, 2'd2, 2'd3, 10'h201), 1'b1);
    push(mk(2'b00, 2'd0, 2'd2, 10'h202), 1'b1);
    push(mk(2'b10, 2'd3, 2'd0, 10'h203), 1'b1);
    push(mk(2'b11, 2'd1, 2'd1, 10'h204), 1'b1);
    wait_req(5'b00000, "pkt_req_fall");
    check("pkt_pops", pop_cnt - p0, 32'd4);
    step(1);
    @(negedge clk);
    check("pkt_gap_req", {27'd0, req}, 32'd0);
    check("pkt_gap_pops", pop_cnt - p0, 32'd4);
    step(1);
    @(negedge clk);
    check("pkt_next_req", {27'd0, req}, {27'd0, 5'b00001});
    wait_req(5'b00000, "pkt_next_fall");
    check("pkt_next_pops", pop_cnt - p0, 32'd5);
    step(1);

    // Stray body flit while idle is discarded.
    exp_drop = 1;
    push(mk(2'b00, 2'd3, 2'd1, 10'h300), 1'b0);
    step(2);
    @(negedge clk);
    check("drop_cnt_one", {24'd0, drop_cnt}, exp_drop);
    check("drop_req", {27'd0, req}, 32'd0);
    check("drop_in_ready", {31'd0, in_ready}, 32'd1);
    step(1);

    for (int i = 0; i < 258; i++) push(mk(2'b10, 2'd0, 2'd0, 10'(i)), 1'b0);
    step(3);
    @(negedge clk);
    check("drop_cnt_sat", {24'd0, drop_cnt}, 32'd255);
    check("drop_sat_req", {27'd0, req}, 32'd0);
    step(1);

    // Backpressure: no grants, FIFO fills after four pushes, fifth waits.
    set_port(4, 5'b10000);
    gnt_mode  = 1'b1;
    gnt_force = 5'b00000;
    p0 = pop_cnt;
    f0 = mk(2'b01, 2'd0, 2'd1, 10'h400);
    push(f0, 1'b1);
    push(mk(2'b00, 2'd1, 2'd1, 10'h401), 1'b1);
    push(mk(2'b00, 2'd2, 2'd1, 10'h402), 1'b1);
    push(mk(2'b00, 2'd3, 2'd1, 10'h403), 1'b1);
    in_flit  = mk(2'b10, 2'd0, 2'd0, 10'h404);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      check("full_head", {16'd0, out_flit}, {16'd0, f0});
      step(1);
    end
    gnt_mode = 1'b0;
    push(mk(2'b10, 2'd0, 2'd0, 10'h404), 1'b1);
    wait_req(5'b00000, "full_req_fall");
    check("full_pops", pop_cnt - p0, 32'd5);
    step(1);

    // Downstream stall with grant high: head must not move.
    set_port(1, 5'b00010);
    out_ready = 1'b0;
    p0 = pop_cnt;
    push(mk(2'b01, 2'd1, 2'd3, 10'h500), 1'b1);
    push(mk(2'b00, 2'd0, 2'd0, 10'h501), 1'b1);
    push(mk(2'b10, 2'd0, 2'd0, 10'h502), 1'b1);
    wait_req(5'b00010, "stall_req");
    f0 = mk(2'b01, 2'd1, 2'd3, 10'h500);
    for (int i = 0; i < 3; i++) begin
      step(1);
      @(negedge clk);
      check("stall_out_flit", {16'd0, out_flit}, {16'd0, f0});
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    step(1);
    out_ready = 1'b1;
    wait_req(5'b00000, "stall_req_fall");
    check("stall_pops", pop_cnt - p0, 32'd3);
    step(1);

    // Grants on every other output must not pop.
    set_port(3, 5'b01000);
    gnt_mode  = 1'b1;
    gnt_force = 5'b10111;
    p0 = pop_cnt;
    f0 = mk(2'b11, 2'd1, 2'd0, 10'h600);
    push(f0, 1'b1);
    wait_req(5'b01000, "wrong_gnt_req");
    for (int i = 0; i < 3; i++) begin
      step(1);
      @(negedge clk);
      check("wrong_gnt_flit", {16'd0, out_flit}, {16'd0, f0});
      check("wrong_gnt_valid", {31'd0, out_valid}, 32'd1);
    end
    step(1);
    gnt_mode = 1'b0;
    wait_req(5'b00000, "wrong_gnt_fall");
    check("wrong_gnt_pops", pop_cnt - p0, 32'd1);
    step(1);

    // Reset in the middle of a packet flushes it.
    set_port(2, 5'b00100);
    push(mk(2'b01, 2'd2, 2'd2, 10'h700), 1'b1);
    push(mk(2'b00, 2'd0, 2'd0, 10'h701), 1'b1);
    rst = 1'b1;
    sb.delete();
    step(1);
    rst = 1'b0;
    p0 = pop_cnt;
    @(negedge clk);
    check("mid_rst_req", {27'd0, req}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    step(4);
    @(negedge clk);
    check("post_rst_req", {27'd0, req}, 32'd0);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_pops", pop_cnt - p0, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_port_rc.md
INPUT_PORT_RC -- requirements
Module: input_port_rc

Interface
REQ-001 The block SHALL use clock clk, and reset rst, which is synchronous and active-high.
REQ-002 Parameter FLIT_W, default 16, SHALL set the flit width in bits (minimum 8).
REQ-003 Parameter DEPTH, default 4, SHALL set the FIFO depth in flits (power of two, at least 2).
REQ-004 Parameters CUR_X and CUR_Y, default 1 and 1, SHALL give this router's 2-bit mesh coordinates.
REQ-005 Port clk SHALL be an input, 1 bit: the clock.
REQ-006 Port rst SHALL be an input, 1 bit: the reset.
REQ-007 Port in_flit SHALL be an input, FLIT_W bits: the flit from the upstream link.
REQ-008 Port in_valid SHALL be an input, 1 bit: in_flit is valid.
REQ-009 Port in_ready SHALL be an output, 1 bit: the FIFO can accept a flit.
REQ-010 Port out_flit SHALL be an output, FLIT_W bits: the FIFO head flit driven to the crossbar.
REQ-011 Port out_valid SHALL be an output, 1 bit: out_flit is valid for the granted output.
REQ-012 Port out_ready SHALL be an input, 1 bit: the downstream output port accepts a flit.
REQ-013 Port req SHALL be an output, 5 bits: one-hot request to the five output arbiters (0 local, 1 north, 2 east, 3 south, 4 west).
REQ-014 Port gnt SHALL be an input, 5 bits: the grant returned from each output arbiter for this input.
REQ-015 Port drop_cnt SHALL be an output, 8 bits: a saturating count of dropped non-head flits.

Function
REQ-016 Flit type SHALL be taken from in_flit[FLIT_W-1:FLIT_W-2]: 01 head, 00 body, 10 tail, 11 single (head and tail).
REQ-017 A head or single flit SHALL carry destination X in bits [3:2] and destination Y in bits [1:0].
REQ-018 The FIFO SHALL push when in_valid and in_ready are both high; in_ready SHALL equal (count != DEPTH).
REQ-019 The FIFO SHALL pop when out_valid, gnt[port] and out_ready are all high; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-020 out_flit SHALL always show the FIFO head combinationally; its value is don't-care when the FIFO is empty.
REQ-021 The FSM SHALL have three states: IDLE, ROUTE and ACTIVE.
REQ-022 In IDLE, if the FIFO is non-empty and the head is a head or single flit, the next state SHALL be ROUTE.
REQ-023 In IDLE, if the FIFO is non-empty and the head is a body or tail flit, that flit SHALL be popped and discarded, drop_cnt SHALL increment (saturating at 255), and the FSM SHALL stay in IDLE.
REQ-024 In ROUTE, XY routing SHALL be latched into the register port, in this priority order: dstX>CUR_X gives east; dstX<CUR_X gives west; dstY>CUR_Y gives north; dstY<CUR_Y gives south; otherwise local.
REQ-025 ROUTE SHALL always be followed by ACTIVE on the next clock edge.
REQ-026 req SHALL be registered and equal onehot(port) exactly while the state is ACTIVE, and 0 in every other state.
REQ-027 out_valid SHALL equal (state==ACTIVE) AND the FIFO is non-empty.
REQ-028 In ACTIVE, req SHALL remain asserted while the FIFO is empty mid-packet; the arbiter hold is never released before the tail.
REQ-029 A pop of a tail or single flit in ACTIVE SHALL move the FSM to IDLE, so req falls on the next edge.
REQ-030 While not in ACTIVE, gnt SHALL be ignored; no pop occurs from the trailing grant cycle after req falls.
REQ-031 A gnt bit other than gnt[port] SHALL never cause a pop.
REQ-032 A new head flit queued behind a tail SHALL pass through IDLE and ROUTE again, giving at least two idle cycles between packets.

Reset
REQ-033 On rst the block SHALL set state to IDLE, the FIFO pointers and count to 0, port to 0, req to 0, and drop_cnt to 0.
REQ-034 After reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-035 An rst asserted mid-packet SHALL flush the FIFO and drop req on the same edge, with no flit emitted afterwards.

Verification
REQ-036 Bench: CUR=(1,1); push a single flit with dst (3,1); arbiter model grants one cycle after req -> req=00100 after the third edge from the push, one pop, then req=0.
REQ-037 Bench: head with dst (1,1), two body flits, then tail -> req=00001 is held for all four pops; no pop occurs in the cycle after req falls.
REQ-038 Bench: push 5 flits back-to-back with gnt held at 0 -> in_ready=0 after four pushes; the fifth flit is held until a pop.
REQ-039 Bench: push a body flit while IDLE -> the flit is discarded, drop_cnt=1, and req stays 0.
REQ-040 Bench: during a packet, drive out_ready=0 for 3 cycles with gnt high -> no pop and no change to out_flit.
REQ-041 Bench: assert rst after the second flit of a packet -> next cycle req=0, out_valid=0, in_ready=1.
